// File: rtl/lv_pkg.sv
// rtl/lv_pkg.sv - shared types and defaults for the LV-side PWM conditioning path
package lv_pkg;

    typedef enum logic [1:0] {
        PWM_OFF   = 2'd0,
        PWM_ON    = 2'd1,
        PWM_FSAFE = 2'd2
    } pwm_dt_st_e;

    localparam int DGLT_CYC_DEF = 4;
    localparam int PW_W_DEF     = 8;

    // Number of bits needed to count up to n (at least one bit).
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lv_dglt.sv
// rtl/lv_dglt.sv - 2-flop synchroniser plus consecutive-sample deglitch filter for one pin
module lv_dglt
    import lv_pkg::*;
#(
    parameter int   DGLT_CYC = DGLT_CYC_DEF,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic filt
);

    localparam int CW = cnt_bits(DGLT_CYC);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] run_cnt;

    // Two-stage synchroniser; both stages reset to the pin's idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= RST_VAL;
            sync_b <= RST_VAL;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
        end
    end

    // Filtered value flips only after DGLT_CYC consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt    <= RST_VAL;
            run_cnt <= '0;
        end else if (sync_b == filt) begin
            run_cnt <= '0;
        end else if (run_cnt == CW'(DGLT_CYC - 1)) begin
            filt    <= sync_b;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lv_pwm_dt.sv
// rtl/lv_pwm_dt.sv - LV PWM conditioning top: sync, deglitch, interlock, min pulse width, fail-safe; LV_PWM_DT_STAT_EN adds ON-entry counter
module lv_pwm_dt
    import lv_pkg::*;
#(
    parameter int DGLT_CYC = DGLT_CYC_DEF,
    parameter int PW_W     = PW_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_inp,
    input  logic            i_inn,
    input  logic            i_en,
    input  logic [PW_W-1:0] i_min_pw,
    input  logic            i_fault,
    input  logic            i_fault_clr,
    output logic            o_drv,
    output logic            o_fsafe,
    output logic [15:0]     o_edge_cnt
);

    logic            inp_f;
    logic            inn_f;
    logic            req;
    logic            pw_ok;
    pwm_dt_st_e      state;
    pwm_dt_st_e      state_n;
    logic [PW_W-1:0] pw_cnt;
    logic [PW_W-1:0] pw_cnt_n;
    logic [PW_W-1:0] pw_cnt_inc;

    lv_dglt #(
        .DGLT_CYC (DGLT_CYC),
        .RST_VAL  (1'b0)
    ) u_dglt_inp (
        .clk  (i_clk),
        .rst  (i_rst),
        .pin  (i_inp),
        .filt (inp_f)
    );

    // The inhibit pin idles high so a reset never opens the interlock.
    lv_dglt #(
        .DGLT_CYC (DGLT_CYC),
        .RST_VAL  (1'b1)
    ) u_dglt_inn (
        .clk  (i_clk),
        .rst  (i_rst),
        .pin  (i_inn),
        .filt (inn_f)
    );

    assign req        = inp_f & ~inn_f & i_en;
    assign pw_ok      = (pw_cnt >= i_min_pw);
    assign pw_cnt_inc = (&pw_cnt) ? pw_cnt : pw_cnt + 1'b1;

    // Next-state logic; fault always wins, and FSAFE exits only on a clean clear.
    always_comb begin
        state_n  = state;
        pw_cnt_n = pw_cnt_inc;
        case (state)
            PWM_OFF: begin
                if (i_fault) begin
                    state_n = PWM_FSAFE;
                end else if (req && pw_ok) begin
                    state_n  = PWM_ON;
                    pw_cnt_n = '0;
                end
            end
            PWM_ON: begin
                if (i_fault) begin
                    state_n = PWM_FSAFE;
                end else if (!req && pw_ok) begin
                    state_n  = PWM_OFF;
                    pw_cnt_n = '0;
                end
            end
            PWM_FSAFE: begin
                pw_cnt_n = pw_cnt;
                if (i_fault_clr && !i_fault) begin
                    state_n  = PWM_OFF;
                    pw_cnt_n = '0;
                end
            end
            default: begin
                state_n  = PWM_OFF;
                pw_cnt_n = '0;
            end
        endcase
    end

    // State, width counter and registered outputs all move on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= PWM_OFF;
            pw_cnt  <= '0;
            o_drv   <= 1'b0;
            o_fsafe <= 1'b0;
        end else begin
            state   <= state_n;
            pw_cnt  <= pw_cnt_n;
            o_drv   <= (state_n == PWM_ON);
            o_fsafe <= (state_n == PWM_FSAFE);
        end
    end

`ifdef LV_PWM_DT_STAT_EN
    logic [15:0] edge_cnt;

    // Counts OFF->ON entries, saturating; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            edge_cnt <= '0;
        end else if ((state == PWM_OFF) && (state_n == PWM_ON) && (edge_cnt != 16'hFFFF)) begin
            edge_cnt <= edge_cnt + 16'd1;
        end
    end

    assign o_edge_cnt = edge_cnt;
`else
    assign o_edge_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lv_pwm_dt.sv
// tb/tb_lv_pwm_dt.sv - self-checking bench for lv_pwm_dt against a behavioural pin-to-drive model
module tb_lv_pwm_dt;

    localparam int DGLT = 4;
    localparam int PW_W = 8;
    localparam int M_OFF = 0;
    localparam int M_ON  = 1;
    localparam int M_FS  = 2;
`ifdef LV_PWM_DT_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            inp;
    logic            inn;
    logic            en;
    logic [PW_W-1:0] min_pw;
    logic            fault;
    logic            fault_clr;
    logic            o_drv;
    logic            o_fsafe;
    logic [15:0]     o_edge_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model: pin samples, filtered levels, state, cycles since last change.
    bit [1:0] m_s1;
    bit [1:0] m_s2;
    bit [1:0] m_filt;
    bit       h_inp[$];
    bit       h_inn[$];
    int       m_st;
    int       m_since;
    int       m_edges;
    bit       e_drv;
    bit       e_fsafe;
    int       e_cnt;

    lv_pwm_dt #(
        .DGLT_CYC (DGLT),
        .PW_W     (PW_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_inp       (inp),
        .i_inn       (inn),
        .i_en        (en),
        .i_min_pw    (min_pw),
        .i_fault     (fault),
        .i_fault_clr (fault_clr),
        .o_drv       (o_drv),
        .o_fsafe     (o_fsafe),
        .o_edge_cnt  (o_edge_cnt)
    );

    always #5 clk = ~clk;

    // True when the last DGLT synchronised samples all disagree with the filtered level.
    function automatic bit flips(input bit q[$], input bit f);
        if (q.size() < DGLT) return 1'b0;
        for (int j = 0; j < DGLT; j++)
            if (q[q.size() - 1 - j] == f) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit req;
        if (rst) begin
            m_s1 = 2'b10; m_s2 = 2'b10; m_filt = 2'b10;
            h_inp.delete(); h_inn.delete();
            m_st = M_OFF; m_since = 0; m_edges = 0;
        end else begin
            req = m_filt[0] && !m_filt[1] && en;
            case (m_st)
                M_OFF: if (fault) m_st = M_FS;
                       else if (req && m_since >= int'(min_pw)) begin
                           m_st = M_ON; m_since = 0;
                           if (m_edges < 65535) m_edges++;
                       end else m_since++;
                M_ON:  if (fault) m_st = M_FS;
                       else if (!req && m_since >= int'(min_pw)) begin m_st = M_OFF; m_since = 0; end
                       else m_since++;
                default: if (fault_clr && !fault) begin m_st = M_OFF; m_since = 0; end
            endcase
            h_inp.push_back(m_s2[0]);
            h_inn.push_back(m_s2[1]);
            if (h_inp.size() > 16) void'(h_inp.pop_front());
            if (h_inn.size() > 16) void'(h_inn.pop_front());
            if (flips(h_inp, m_filt[0])) m_filt[0] = ~m_filt[0];
            if (flips(h_inn, m_filt[1])) m_filt[1] = ~m_filt[1];
            m_s2 = m_s1;
            m_s1 = {inn, inp};
        end
        e_drv   = (m_st == M_ON);
        e_fsafe = (m_st == M_FS);
        e_cnt   = STAT ? m_edges : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; inp = 1'b1; inn = 1'b0; en = 1'b1; min_pw = '0; fault = 1'b0; fault_clr = 1'b0;
        idle(3);
        checks++; if (o_drv !== 1'b0) begin errors++; $display("FAIL reset_drv got=%0b exp=0", o_drv); end
        checks++; if (o_fsafe !== 1'b0) begin errors++; $display("FAIL reset_fsafe got=%0b exp=0", o_fsafe); end
        checks++; if (o_edge_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", o_edge_cnt); end
        rst = 1'b0; inp = 1'b0;
        idle(20);
    endtask

    task automatic test_basic_edge();
        int n;
        min_pw = '0; en = 1'b1; inn = 1'b0; inp = 1'b0;
        idle(20);
        for (int dir = 1; dir >= 0; dir--) begin
            inp = dir[0];
            n = 0;
            do begin
                tick(); n++;
                checks++; if (o_drv !== e_drv) begin errors++; $display("FAIL basic_drv got=%0b exp=%0b t=%0t", o_drv, e_drv, $time); end
            end while (o_drv !== dir[0] && n < 40);
            checks++; if (n != 7) begin errors++; $display("FAIL basic_latency dir=%0d got=%0d exp=7", dir, n); end
            idle(10);
        end
    endtask

    task automatic test_glitch();
        bit seen;
        for (int w = 3; w <= 4; w++) begin
            seen = 1'b0;
            inp = 1'b1;
            for (int i = 0; i < w; i++) begin tick(); seen |= o_drv; end
            inp = 1'b0;
            for (int i = 0; i < 25; i++) begin
                tick(); seen |= o_drv;
                checks++; if (o_drv !== e_drv) begin errors++; $display("FAIL glitch_drv got=%0b exp=%0b t=%0t", o_drv, e_drv, $time); end
            end
            checks++; if (seen !== (w == 4)) begin errors++; $display("FAIL glitch_width w=%0d got=%0b exp=%0b", w, seen, (w == 4)); end
        end
    endtask

    task automatic test_min_pw();
        int n, hi, lo;
        min_pw = 8'd20; inp = 1'b0;
        idle(30);
        inp = 1'b1; idle(5); inp = 1'b0;
        n = 0;
        while (o_drv !== 1'b1 && n < 40) begin tick(); n++; end
        hi = 0;
        while (o_drv === 1'b1 && hi < 60) begin
            hi++; tick();
            checks++; if (o_drv !== e_drv) begin errors++; $display("FAIL minpw_drv got=%0b exp=%0b t=%0t", o_drv, e_drv, $time); end
        end
        checks++; if (hi != 21) begin errors++; $display("FAIL minpw_on got=%0d exp=21", hi); end
        inp = 1'b1;
        lo = 0;
        while (o_drv !== 1'b1 && lo < 60) begin
            lo++; tick();
            checks++; if (o_fsafe !== e_fsafe) begin errors++; $display("FAIL minpw_fsafe got=%0b exp=%0b", o_fsafe, e_fsafe); end
        end
        checks++; if (lo != 21) begin errors++; $display("FAIL minpw_off got=%0d exp=21", lo); end
        inp = 1'b0; min_pw = '0;
        idle(40);
    endtask

    task automatic test_interlock();
        int n;
        bit seen;
        seen = 1'b0;
        en = 1'b0; inn = 1'b0; inp = 1'b1;
        for (int i = 0; i < 20; i++) begin tick(); seen |= o_drv; end
        inn = 1'b1; idle(10); en = 1'b1;
        for (int i = 0; i < 20; i++) begin tick(); seen |= o_drv; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL interlock_blocked got=%0b exp=0", seen); end
        inn = 1'b0;
        n = 0;
        do begin tick(); n++; end while (o_drv !== 1'b1 && n < 40);
        checks++; if (n != 7) begin errors++; $display("FAIL interlock_release got=%0d exp=7", n); end
        inp = 1'b0;
        idle(20);
    endtask

    task automatic test_fault();
        int n;
        min_pw = 8'd20; inp = 1'b0;
        idle(30);
        inp = 1'b1;
        n = 0;
        while (o_drv !== 1'b1 && n < 40) begin tick(); n++; end
        idle(3);
        fault = 1'b1; tick();
        checks++; if (o_drv !== 1'b0 || o_fsafe !== 1'b1) begin errors++; $display("FAIL fault_entry got=%0b%0b exp=01", o_drv, o_fsafe); end
        fault_clr = 1'b1; tick(); fault_clr = 1'b0; tick();
        checks++; if (o_fsafe !== 1'b1) begin errors++; $display("FAIL fault_clr_ignored got=%0b exp=1", o_fsafe); end
        fault = 1'b0; tick();
        checks++; if (o_fsafe !== 1'b1) begin errors++; $display("FAIL fault_hold got=%0b exp=1", o_fsafe); end
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        checks++; if (o_fsafe !== 1'b0 || o_drv !== 1'b0) begin errors++; $display("FAIL fault_exit got=%0b%0b exp=00", o_drv, o_fsafe); end
        n = 1;
        while (o_drv !== 1'b1 && n < 60) begin
            tick(); if (o_drv !== 1'b1) n++;
            checks++; if (o_drv !== e_drv) begin errors++; $display("FAIL fault_model got=%0b exp=%0b t=%0t", o_drv, e_drv, $time); end
        end
        checks++; if (n != 21) begin errors++; $display("FAIL fault_minoff got=%0d exp=21", n); end
        inp = 1'b0; min_pw = '0;
        idle(40);
    endtask

    task automatic test_reset_mid();
        int n;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int p = 0; p < 3; p++) begin
            inp = 1'b1; idle(12); inp = 1'b0; idle(12);
        end
        checks++; if (o_edge_cnt !== 16'(STAT ? 3 : 0)) begin errors++; $display("FAIL stat_count got=%0d exp=%0d", o_edge_cnt, STAT ? 3 : 0); end
        inp = 1'b1;
        n = 0;
        while (o_drv !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (o_drv !== 1'b1) begin errors++; $display("FAIL rstmid_on got=%0b exp=1", o_drv); end
        rst = 1'b1; tick();
        checks++; if (o_drv !== 1'b0 || o_edge_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_clear got=%0b/%0d exp=0/0", o_drv, o_edge_cnt); end
        rst = 1'b0; inp = 1'b0;
        idle(20);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) inp = ~inp;
            if ($urandom_range(19) == 0) inn = ($urandom_range(3) == 0);
            if ($urandom_range(49) == 0) en = ($urandom_range(7) != 0);
            if ($urandom_range(149) == 0) fault = ~fault;
            fault_clr = ($urandom_range(19) == 0);
            if ($urandom_range(299) == 0) min_pw = PW_W'($urandom_range(30));
            rst = ($urandom_range(1499) == 0);
            tick();
            checks++; if (o_drv !== e_drv) begin errors++; $display("FAIL rand_drv got=%0b exp=%0b t=%0t", o_drv, e_drv, $time); end
            checks++; if (o_fsafe !== e_fsafe) begin errors++; $display("FAIL rand_fsafe got=%0b exp=%0b t=%0t", o_fsafe, e_fsafe, $time); end
            checks++; if (o_edge_cnt !== 16'(e_cnt)) begin errors++; $display("FAIL rand_cnt got=%0d exp=%0d t=%0t", o_edge_cnt, e_cnt, $time); end
        end
        rst = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_edge();
        test_glitch();
        test_min_pw();
        test_interlock();
        test_fault();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
